// File: rtl/pp_pipeline_accel_mac_share_arb.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_mac_share_arb
//
// Shares one external muladd DSP (unsigned din0 x signed din1 + signed din2,
// MAC_LAT ce-gated register stages) among NUM_REQ valid/ready requesters.
// A round-robin arbiter grants at most one requester per cycle. The winner's
// multiplicand and multiplier go straight to the DSP. Its addend travels
// through a (MAC_LAT-1)-deep delay line so that it reaches the DSP's late C
// input in the same cycle as the matching product. A valid/tag shift pipe of
// depth MAC_LAT runs alongside the DSP and marks which requester owns each
// result. Output backpressure drops mac_ce, which freezes the DSP and every
// internal pipe together, so the result on the output holds still until the
// sink accepts it.
//
// Optional feature (macro PP_MAC_ARB_STATS_EN): adds per-requester 16-bit
// saturating grant counters on grant_cnt, plus a synchronous clear_stats
// input. When the macro is undefined those ports and counters do not exist.
// ---------------------------------------------------------------------------
module pp_pipeline_accel_mac_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DIN0_W  = 12,
  parameter int DIN1_W  = 9,
  parameter int DIN2_W  = 21,
  parameter int DOUT_W  = 22,
  parameter int MAC_LAT = 3,
  localparam int TAG_W  = $clog2(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
  input  logic [NUM_REQ*DIN2_W-1:0] req_din2,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [TAG_W-1:0]          res_tag,
  output logic [DOUT_W-1:0]         res_data,
  output logic                      idle,
  output logic                      mac_ce,
  output logic [DIN0_W-1:0]         mac_din0,
  output logic [DIN1_W-1:0]         mac_din1,
  output logic [DIN2_W-1:0]         mac_din2,
  input  logic [DOUT_W-1:0]         mac_dout
`ifdef PP_MAC_ARB_STATS_EN
  ,
  input  logic                      clear_stats,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN
  } state_e;

  // Per-requester operand views of the packed input buses
  logic [DIN0_W-1:0] din0_arr [NUM_REQ];
  logic [DIN1_W-1:0] din1_arr [NUM_REQ];
  logic [DIN2_W-1:0] din2_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign din0_arr[g] = req_din0[g*DIN0_W +: DIN0_W];
    assign din1_arr[g] = req_din1[g*DIN1_W +: DIN1_W];
    assign din2_arr[g] = req_din2[g*DIN2_W +: DIN2_W];
  end

  // Arbitration
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             win_found;
  logic [TAG_W-1:0] win_idx;
  logic             grant;

  // Shift pipes: valid/tag run alongside the DSP, addend meets its late C input
  logic [MAC_LAT-1:0]             vld_q, vld_d;
  logic [MAC_LAT-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [MAC_LAT-2:0][DIN2_W-1:0] add_q, add_d;
  logic                           pipe_busy_d;

  // FSM state and its registered output
  state_e state_q;
  logic   idle_q;

  // Output stage and backpressure: a held result freezes everything behind it
  assign res_valid = vld_q[MAC_LAT-1];
  assign res_tag   = tag_q[MAC_LAT-1];
  assign res_data  = mac_dout;
  assign mac_ce    = ~(res_valid & ~res_ready);
  assign idle      = idle_q;

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping
  always_comb begin : arb_search
    int k;
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_found && req_valid[TAG_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = TAG_W'(k);
      end
    end
  end

  // A grant needs a moving pipe, enable and a requester. The reset term keeps
  // req_ready low while reset is held, since this path is purely combinational.
  assign grant = ap_rst_n & mac_ce & enable & win_found;

  // One-hot ready to the winner only, in the grant cycle
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  // Winner's multiplicand/multiplier go straight to the DSP; zero on bubbles
  always_comb begin
    mac_din0 = '0;
    mac_din1 = '0;
    if (grant) begin
      mac_din0 = din0_arr[win_idx];
      mac_din1 = din1_arr[win_idx];
    end
  end

  // Addend leaves the tail of the delay line as its product reaches the C stage
  assign mac_din2 = add_q[MAC_LAT-2];

  // Next state of the valid/tag/addend pipes and the round-robin pointer
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    add_d    = add_q;
    rr_ptr_d = rr_ptr_q;
    if (mac_ce) begin
      vld_d    = {vld_q[MAC_LAT-2:0], grant};
      tag_d[0] = grant ? win_idx : '0;
      for (int s = 1; s < MAC_LAT; s++) tag_d[s] = tag_q[s-1];
      add_d[0] = grant ? din2_arr[win_idx] : '0;
      for (int s = 1; s < MAC_LAT - 1; s++) add_d[s] = add_q[s-1];
    end
    if (grant) begin
      rr_ptr_d = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + TAG_W'(1);
    end
  end

  // Whether anything is still in flight after this cycle's shift
  assign pipe_busy_d = |vld_d;

  // Pipe and pointer registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: the addend delay line is a handful of flops, not a RAM, and is
      // cleared so that a freshly reset pipe presents a zero addend.
      vld_q    <= '0;
      tag_q    <= '0;
      add_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // that all flops sample their _d values from the same clock edge.
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      add_q    <= add_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Operating mode: IDLE until the first grant, DRAIN while enable is low
  // with results in flight, back to IDLE once the pipe has emptied
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q <= ST_BUSY;
            idle_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!pipe_busy_d) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end else if (!enable) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy_d) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end else if (enable) begin
            state_q <= ST_BUSY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PP_MAC_ARB_STATS_EN
  // Per-requester grant counters; clear wins over a same-cycle grant
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

  // Counter next state: saturating increment on the winner's counter
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (clear_stats) begin
        cnt_d[i] = '0;
      end else if (grant && (win_idx == TAG_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_mac_share_arb.sv
// ---------------------------------------------------------------------------
// tb_pp_pipeline_accel_mac_share_arb
//
// Directed bench for the shared-MAC arbiter. The bench supplies its own
// ce-gated 3-stage muladd model on mac_dout. A table of single transactions
// with hand-computed results checks the data path, tag and latency. Short
// hand-written sequences cover round-robin order and throughput, output
// stall, drain on enable low, and reset with results in flight.
// ---------------------------------------------------------------------------
module tb_pp_pipeline_accel_mac_share_arb;

  localparam int NR = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_din0;
  logic [35:0] req_din1;
  logic [83:0] req_din2;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_tag;
  logic [21:0] res_data;
  logic        idle;
  logic        mac_ce;
  logic [11:0] mac_din0;
  logic [8:0]  mac_din1;
  logic [20:0] mac_din2;
  logic [21:0] mac_dout;

  // Requester operand registers
  logic [11:0]        op0 [NR];
  logic signed [8:0]  op1 [NR];
  logic signed [20:0] op2 [NR];

  assign req_din0 = {op0[3], op0[2], op0[1], op0[0]};
  assign req_din1 = {op1[3], op1[2], op1[1], op1[0]};
  assign req_din2 = {op2[3], op2[2], op2[1], op2[0]};

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_mac_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .req_din2  (req_din2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .idle      (idle),
    .mac_ce    (mac_ce),
    .mac_din0  (mac_din0),
    .mac_din1  (mac_din1),
    .mac_din2  (mac_din2),
    .mac_dout  (mac_dout)
  );

  // Shared muladd DSP model: A/B registered, product registered, C added late
  logic [11:0]        dsp_a_q;
  logic signed [8:0]  dsp_b_q;
  logic signed [21:0] dsp_m_q;
  logic signed [21:0] dsp_p_q;

  always_ff @(posedge ap_clk) begin
    if (mac_ce) begin
      dsp_a_q <= mac_din0;
      dsp_b_q <= mac_din1;
      dsp_m_q <= $signed({1'b0, dsp_a_q}) * dsp_b_q;
      dsp_p_q <= dsp_m_q + $signed(mac_din2);
    end
  end
  assign mac_dout = dsp_p_q;

  // Bookkeeping
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_ptr = 0;

  typedef struct {
    logic [1:0]         tag;
    logic signed [21:0] data;
  } exp_t;
  exp_t sb_q [$];

  typedef struct {
    logic [1:0]         req;
    logic [11:0]        din0;
    logic signed [8:0]  din1;
    logic signed [20:0] din2;
    logic signed [21:0] res;
  } vec_t;

  localparam int NV = 8;
  vec_t vec [NV];

  function automatic logic signed [21:0] model(input logic [11:0] a,
                                               input logic signed [8:0] b,
                                               input logic signed [20:0] c);
    logic signed [21:0] r;
    r = $signed({1'b0, a}) * b + c;
    return r;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  // One clock slot: check the expected grant, score any delivered result
  task automatic tick(input logic [3:0] exp_ready);
    exp_t e;
    int   w;
    #1;
    check("req_ready", req_ready, exp_ready);
    if (exp_ready != 4'd0) begin
      w = 0;
      for (int k = 0; k < NR; k++) if (exp_ready[k]) w = k;
      e.tag  = 2'(w);
      e.data = model(op0[w], op1[w], op2[w]);
      sb_q.push_back(e);
      exp_ptr = (w + 1) % NR;
    end
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_res_valid", res_valid, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_tag", res_tag, e.tag);
        check("sb_data", $signed(res_data), e.data);
      end
    end
    cyc();
  endtask

  task automatic drain(output int n);
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick(4'd0);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no $finish, want $finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   n;

    vec[0] = '{2'd0, 12'd4095, 9'h100,     21'sd0,       -22'sd1048320};
    vec[1] = '{2'd2, 12'd10,   9'sd3,      -21'sd7,      22'sd23};
    vec[2] = '{2'd1, 12'd4095, 9'sd255,    21'sd1048575, 22'sd2092800};
    vec[3] = '{2'd3, 12'd0,    -9'sd1,     21'h100000,   -22'sd1048576};
    vec[4] = '{2'd1, 12'd4095, 9'h100,     21'h100000,   -22'sd2096896};
    vec[5] = '{2'd2, 12'd1,    9'sd1,      21'sd0,       22'sd1};
    vec[6] = '{2'd3, 12'd123,  -9'sd45,    21'sd1000,    -22'sd4535};
    vec[7] = '{2'd0, 12'd2048, 9'sd100,    -21'sd300000, -22'sd95200};

    for (int i = 0; i < NR; i++) begin
      op0[i] = '0;
      op1[i] = '0;
      op2[i] = '0;
    end
    enable    = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'hF;

    // Reset state, with every requester asking
    #2;
    ap_rst_n = 1'b0;
    cyc();
    cyc();
    check("rst_res_valid", res_valid, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_idle", idle, 1);
    check("rst_mac_ce", mac_ce, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_mac_din2", mac_din2, 0);
    req_valid = 4'h0;
    ap_rst_n  = 1'b1;
    cyc();

    // Single transactions: ready, latency, data and tag
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      op0[v.req] = v.din0;
      op1[v.req] = v.din1;
      op2[v.req] = v.din2;
      req_valid  = 4'b0001 << v.req;
      #1;
      check("vec_ready", req_ready, 4'b0001 << v.req);
      cyc();
      req_valid = 4'h0;
      exp_ptr   = (int'(v.req) + 1) % NR;
      n = 1;
      while (!res_valid && n < 10) begin
        cyc();
        n++;
      end
      check("vec_latency", n, 3);
      check("vec_data", $signed(res_data), v.res);
      check("vec_tag", res_tag, v.req);
      cyc();
    end
    check("vec_idle_after", idle, 1);

    // All requesters valid: round-robin order, one result per cycle
    for (int i = 0; i < NR; i++) begin
      op0[i] = 12'(100 * (i + 1));
      op1[i] = 9'(-3 - i);
      op2[i] = 21'(1000 * i - 5000);
    end
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) tick(4'b0001 << exp_ptr);
    req_valid = 4'h0;
    drain(n);
    check("rr_drain_cycles", n, 3);

    // Output stall: result held, ce low, no new grant
    op0[2] = 12'd10;
    op1[2] = 9'sd3;
    op2[2] = -21'sd7;
    op0[0] = 12'd7;
    op1[0] = -9'sd2;
    op2[0] = 21'sd50;
    res_ready = 1'b0;
    req_valid = 4'b0100;
    tick(4'b0100);
    req_valid = 4'h0;
    tick(4'd0);
    tick(4'd0);
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      #1;
      check("stall_valid", res_valid, 1);
      check("stall_data", $signed(res_data), 23);
      check("stall_tag", res_tag, 2);
      check("stall_mac_ce", mac_ce, 0);
      check("stall_ready", req_ready, 0);
      cyc();
    end
    res_ready = 1'b1;
    tick(4'b0001);
    req_valid = 4'h0;
    drain(n);

    // enable drops with three results in flight
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) tick(4'b0001 << exp_ptr);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_idle_low", idle, 0);
      tick(4'd0);
    end
    check("drain_idle_high", idle, 1);
    check("drain_sb_empty", sb_q.size(), 0);
    #1;
    check("drain_no_ready", req_ready, 0);
    check("drain_res_valid", res_valid, 0);
    cyc();
    req_valid = 4'h0;
    enable    = 1'b1;

    // Reset with results in flight and one stalled at the output
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) tick(4'b0001 << exp_ptr);
    req_valid = 4'h0;
    res_ready = 1'b0;
    #1;
    check("pre_rst_valid", res_valid, 1);
    check("pre_rst_mac_ce", mac_ce, 0);
    req_valid = 4'hF;
    ap_rst_n  = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_mac_ce", mac_ce, 1);
    check("mid_rst_tag", res_tag, 0);
    sb_q.delete();
    exp_ptr   = 0;
    req_valid = 4'h0;
    res_ready = 1'b1;
    cyc();
    cyc();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(4'd0);
    check("post_rst_idle", idle, 1);
    req_valid = 4'hF;
    tick(4'b0001);
    req_valid = 4'h0;
    drain(n);
    check("post_rst_latency", n, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
